// File: rtl/div_sequencer.sv
// Multi-cycle 32-bit restoring divider for DIV/DIVU/REM/REMU with kill and special-case flags.
// Define DIV_EARLY_OUT_EN to finish b==0 and signed-overflow operations in one cycle.
module div_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        kill,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        zero_division,
  output logic        overflow_signed_div
);

`ifdef DIV_EARLY_OUT_EN
  localparam bit EarlyOut = 1'b1;
`else
  localparam bit EarlyOut = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state_q;
  logic        op_rem_q, sign_a_q, sign_b_q, zdiv_q, ovf_q;
  logic [31:0] div_q, rem_q, quot_q;
  logic [5:0]  cnt_q;

  logic        is_signed, a_neg, b_neg, new_zdiv, new_ovf;
  logic [31:0] a_mag, b_mag, early_res, rem_d, quot_d, q_fix, r_fix, fix_res;
  logic [32:0] shifted, diff;

  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & a[31];
    b_neg     = is_signed & b[31];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;
    new_zdiv  = (b == 32'h0000_0000);
    new_ovf   = is_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    early_res = op[1] ? (new_zdiv ? a : 32'h0000_0000)
                      : (new_zdiv ? 32'hFFFF_FFFF : 32'h8000_0000);

    // One restoring step: the dividend streams out of quot_q into rem_q.
    shifted = {rem_q, quot_q[31]};
    diff    = shifted - {1'b0, div_q};
    if (!diff[32]) begin
      rem_d  = diff[31:0];
      quot_d = {quot_q[30:0], 1'b1};
    end else begin
      rem_d  = shifted[31:0];
      quot_d = {quot_q[30:0], 1'b0};
    end

    // NOTE: every signal here is assigned on all paths before any override, so no latch is inferred.
    q_fix = (sign_a_q ^ sign_b_q) ? -quot_q : quot_q;
    if (zdiv_q) q_fix = 32'hFFFF_FFFF;
    r_fix   = sign_a_q ? -rem_q : rem_q;
    fix_res = op_rem_q ? r_fix : q_fix;
  end

  // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q             <= IDLE;
      cnt_q               <= 6'd0;
      busy                <= 1'b0;
      done                <= 1'b0;
      result              <= 32'h0000_0000;
      zero_division       <= 1'b0;
      overflow_signed_div <= 1'b0;
    end else if (kill) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          state_q <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          if (start) begin
            // NOTE: datapath registers are not reset; they are always loaded here before use.
            op_rem_q <= op[1];
            sign_a_q <= a_neg;
            sign_b_q <= b_neg;
            zdiv_q   <= new_zdiv;
            ovf_q    <= new_ovf;
            div_q    <= b_mag;
            quot_q   <= a_mag;
            rem_q    <= 32'h0000_0000;
            cnt_q    <= 6'd0;
            if (EarlyOut && (new_zdiv || new_ovf)) begin
              state_q             <= DONE;
              done                <= 1'b1;
              result              <= early_res;
              zero_division       <= new_zdiv;
              overflow_signed_div <= new_ovf;
            end else begin
              state_q <= CALC;
              busy    <= 1'b1;
            end
          end
        end
        CALC: begin
          rem_q  <= rem_d;
          quot_q <= quot_d;
          cnt_q  <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) state_q <= FIX;
        end
        FIX: begin
          state_q             <= DONE;
          busy                <= 1'b0;
          done                <= 1'b1;
          result              <= fix_res;
          zero_division       <= zdiv_q;
          overflow_signed_div <= ovf_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 The block SHALL have no parameters; the operand width is fixed at 32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a divide/remainder operation; sampled only when the block is accepting.
REQ-005 op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start.
REQ-006 a  input  32  dividend (rs1); sampled with start.
REQ-007 b  input  32  divisor (rs2); sampled with start.
REQ-008 kill  input  1  pipeline flush; abort any operation in progress.
REQ-009 busy  output  1  operation in progress; the pipeline stalls while high.
REQ-010 done  output  1  one-cycle pulse; result and flags valid this cycle.
REQ-011 result  output  32  quotient (DIV/DIVU) or remainder (REM/REMU).
REQ-012 zero_division  output  1  last completed operation had b==0.
REQ-013 overflow_signed_div  output  1  last completed signed operation was 0x80000000 / 0xFFFFFFFF.

Function
REQ-014 The FSM SHALL have four states: IDLE, CALC, FIX and DONE.
REQ-015 Accepting SHALL be defined as state IDLE or DONE; start is ignored in any other state.
REQ-016 Accepted start with no special case SHALL lead to CALC; with a special case, see REQ-023.
REQ-017 On accept, the block SHALL latch op, the operand signs, and the magnitudes |a| and |b|; magnitudes are taken for signed ops only.
REQ-018 CALC SHALL run exactly 32 cycles; each cycle is one restoring radix-2 step: shift {rem,quot} left 1, subtract divisor, keep the difference if it is non-negative, and set the quotient LSB accordingly.
REQ-019 A 6-bit iteration counter SHALL count the CALC cycles; CALC goes to FIX when the count reaches 31.
REQ-020 FIX SHALL apply the signed-op sign corrections: negate the quotient if sign(a) != sign(b); give the remainder the sign of a.
REQ-021 FIX SHALL select the quotient or the remainder per op[1], then go to DONE.
REQ-022 Latency: with start accepted at edge 0, the block is in CALC for cycles 1..32, FIX in cycle 33, and done=1 in cycle 34.
REQ-023 Special cases SHALL produce the following values:
  - b==0: quotient = 0xFFFFFFFF, remainder = a, zero_division = 1.
  - Signed op with a==0x80000000 and b==0xFFFFFFFF: quotient = 0x80000000, remainder = 0, overflow_signed_div = 1.
  - Unsigned ops never set overflow_signed_div.
REQ-024 busy SHALL be 1 in CALC and FIX, and 0 in IDLE and DONE.
REQ-025 done SHALL be 1 only in DONE, for exactly one cycle.
REQ-026 From DONE the FSM SHALL go to CALC (or the special-case path) if start is high, otherwise to IDLE; this permits back-to-back operations.
REQ-027 result and both flags SHALL update only on entry to DONE and hold their values until the next DONE.
REQ-028 kill in any state SHALL force IDLE on the next edge, with no done pulse and result/flags unchanged.
REQ-029 If kill and start are high in the same cycle, kill SHALL win and start SHALL be ignored.
REQ-030 Operand changes on a, b or op after acceptance SHALL have no effect on the operation in progress.

Reset
REQ-031 When rst is high at a rising edge, the state SHALL go to IDLE, the counter to 0, busy=0, done=0, result=0, zero_division=0 and overflow_signed_div=0.
REQ-032 rst SHALL override start and kill, and abort an in-flight operation without a done pulse.

Configuration
REQ-033 The macro DIV_EARLY_OUT_EN SHALL control special-case handling.
REQ-034 With DIV_EARLY_OUT_EN defined, special cases SHALL skip CALC/FIX: accept at edge 0 gives done=1 in cycle 1, and busy stays 0.
REQ-035 Without DIV_EARLY_OUT_EN, special cases SHALL take the full 34-cycle path with the same result and flag values as REQ-023.
REQ-036 Non-special-case behaviour SHALL be identical with and without DIV_EARLY_OUT_EN.

Verification
REQ-037 DIV 100/7 (op=00) -> done=1 in cycle 34, result=14, busy=1 in cycles 1..33, both flags 0.
REQ-038 REM -7/2 (op=10, a=0xFFFFFFF9, b=2) -> result=0xFFFFFFFF (-1); DIVU 0xFFFFFFFF/2 (op=01) -> result=0x7FFFFFFF.
REQ-039 DIVU 5/0 -> result=0xFFFFFFFF and zero_division=1; done=1 in cycle 1 with DIV_EARLY_OUT_EN, in cycle 34 without.
REQ-040 DIV 0x80000000/0xFFFFFFFF -> result=0x80000000 and overflow_signed_div=1; the same operands as REM -> result=0, flag=1.
REQ-041 kill in cycle 10 of a CALC, then start DIVU 9/3 in cycle 12 -> no done for the first op, result=3 with done=1 in cycle 46.
REQ-042 start held high in the DONE cycle with new operands -> second operation accepted, second done exactly 34 cycles later.
